// File: rtl/pipe_pkg.sv
// Shared helpers for the pipelined register slice.
package pipe_pkg;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data pair of the pipeline. The stage loads whenever its
// ready is set; data only moves when a valid word arrives, so bubbles
// never disturb the held data value.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             rdy,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             r_v;
  logic [WIDTH-1:0] r_d;

  // Valid/data update: rst beats flush, flush beats a normal transfer.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; blocking here would let a word
    // ripple through several stages in a single clock.
    if (rst) begin
      r_v <= 1'b0;
      r_d <= RESET_VAL;
    end else if (flush) begin
      // Data is left untouched on flush; only the valid bit is cleared.
      r_v <= 1'b0;
    end else if (rdy) begin
      r_v <= up_valid;
      if (up_valid) begin
        r_d <= up_data;
      end
    end
  end

  assign v = r_v;
  assign d = r_d;

endmodule

// File: rtl/pipe_reg_sync_rst.sv
// DEPTH-stage, WIDTH-bit back-pressurable pipeline register with
// per-stage valid/ready, bubble collapsing, flush and occupancy count.
module pipe_reg_sync_rst
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      flush,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 1) begin : g_depth_check
    $error("pipe_reg_sync_rst: DEPTH must be at least 1");
  end
  if (WIDTH < 1) begin : g_width_check
    $error("pipe_reg_sync_rst: WIDTH must be at least 1");
  end

  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_d       [DEPTH];
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_up_valid;
  logic [WIDTH-1:0] w_up_data [DEPTH];
  logic             w_accept;
  logic             w_emit;
  logic [CW-1:0]    r_count;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // The recursive chain rdy[i] = !v[i] | rdy[i+1] unrolls to "out_ready,
    // or some stage from i to the output is empty". Writing it flat keeps
    // the ready bits independent of one another, so no combinational
    // dependency exists between bits of the same vector.
    assign w_rdy[i] = out_ready | ~(&w_v[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign w_up_valid[i] = in_valid & ~flush;
      assign w_up_data[i]  = in_data;
    end else begin : g_body
      assign w_up_valid[i] = w_v[i-1];
      assign w_up_data[i]  = w_d[i-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (w_up_valid[i]),
      .up_data  (w_up_data[i]),
      .rdy      (w_rdy[i]),
      .v        (w_v[i]),
      .d        (w_d[i])
    );
  end

  // Input side refuses words during a flush; output comes straight from
  // the last stage's flops.
  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = w_v[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];

  assign w_accept = in_valid & in_ready;
  assign w_emit   = out_valid & out_ready;

  // Occupancy: +1 on accept, -1 on emit, cleared by rst or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(w_accept) - CW'(w_emit);
    end
  end

  assign count = r_count;

endmodule
